// File: rtl/uart_pkg.sv
// Shared constants for the UART MMIO controller: register offsets,
// STATUS/CTRL bit positions, the reset baud divisor and the TX FSM states.
package uart_pkg;

    // Register offsets relative to the block base address
    localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;

    // STATUS register bit positions
    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_AVAIL  = 2;
    localparam int ST_RX_FULL   = 3;
    localparam int ST_RX_OVF    = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_TX_BUSY   = 6;
    localparam int ST_TX_OVF    = 7;

    // CTRL register field positions
    localparam int CTRL_DIV_LSB   = 0;
    localparam int CTRL_DIV_MSB   = 15;
    localparam int CTRL_TX_EN     = 16;
    localparam int CTRL_RX_IRQ_EN = 17;

    // Bit-period divisor after reset: 100 MHz clock, 5208 ns bit
    localparam logic [15:0] DIV_RESET_DEFAULT = 16'd521;

    // Transmit handshake FSM
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head so the CPU can see the
// oldest entry in the same cycle it pops it. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: CPU-facing DATA/STATUS/CTRL registers,
// TX and RX byte FIFOs, a two-state TX handshake FSM and a level IRQ.
module uart_mmio_ctrl
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = DIV_RESET_DEFAULT,
    parameter logic [31:0] BASE       = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_frame_err,
    output logic [15:0] baud_div,
    output logic        irq
);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_div_q;
    logic        tx_en_q, rx_irq_en_q;
    logic        rx_ovf_q, frame_err_q, tx_ovf_q, irq_q;

    logic        sel_data, sel_status, sel_ctrl;
    logic        wr_data, wr_status, wr_ctrl, rd_data;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  tx_head, rx_head;
    logic        tx_ovf_set, rx_ovf_set;
    logic [7:0]  status;
    logic        unused_wdata;

    assign sel_data   = (addr == BASE + OFF_DATA);
    assign sel_status = (addr == BASE + OFF_STATUS);
    assign sel_ctrl   = (addr == BASE + OFF_CTRL);
    assign wr_data    = we && sel_data;
    assign wr_status  = we && sel_status;
    assign wr_ctrl    = we && sel_ctrl;
    assign rd_data    = re && sel_data;

    // Only the low 18 bits of store data map to any register field
    assign unused_wdata = ^wdata[31:18];

    assign tx_push = wr_data;
    assign tx_pop  = (state_q == TX_SEND) && tx_ready;
    assign rx_push = rx_valid && !rx_frame_err;
    assign rx_pop  = rd_data;

    // A pop in the same cycle frees the slot, so only a true drop is flagged
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;
    assign rx_ovf_set = rx_push && rx_full && !rx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_push),
        .din     (wdata[7:0]),
        .pop     (tx_pop),
        .full    (tx_full),
        .empty   (tx_empty),
        .head    (tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .din     (rx_data),
        .pop     (rx_pop),
        .full    (rx_full),
        .empty   (rx_empty),
        .head    (rx_head)
    );

    // Assemble STATUS from live FIFO flags and sticky error bits
    always_comb begin
        status               = '0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_RX_AVAIL]  = !rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_RX_OVF]    = rx_ovf_q;
        status[ST_FRAME_ERR] = frame_err_q;
        status[ST_TX_BUSY]   = (state_q != TX_IDLE);
        status[ST_TX_OVF]    = tx_ovf_q;
    end

    // Combinational load data; unmapped addresses read as zero
    always_comb begin
        rdata = '0;
        if (sel_data) begin
            rdata = rx_empty ? 32'h0 : {24'h0, rx_head};
        end else if (sel_status) begin
            rdata = {24'h0, status};
        end else if (sel_ctrl) begin
            rdata = {14'h0, rx_irq_en_q, tx_en_q, baud_div_q};
        end
    end

    // TX FSM next state: start only when enabled, finish only on handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: if (tx_en_q && !tx_empty) state_d = TX_SEND;
            TX_SEND: if (tx_ready)             state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    // TX FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= TX_IDLE;
        else          state_q <= state_d;
    end

    // Control fields, sticky flags and the registered interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_div_q  <= DIV_RESET;
            tx_en_q     <= 1'b1;
            rx_irq_en_q <= 1'b0;
            rx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ovf_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                // A zero divisor would stall the serializer, so it is ignored
                if (wdata[CTRL_DIV_MSB:CTRL_DIV_LSB] != 16'h0)
                    baud_div_q <= wdata[CTRL_DIV_MSB:CTRL_DIV_LSB];
                tx_en_q     <= wdata[CTRL_TX_EN];
                rx_irq_en_q <= wdata[CTRL_RX_IRQ_EN];
            end
            // Set has priority over a same-cycle write-one-to-clear
            if (rx_ovf_set)                         rx_ovf_q <= 1'b1;
            else if (wr_status && wdata[ST_RX_OVF]) rx_ovf_q <= 1'b0;
            if (rx_frame_err)                          frame_err_q <= 1'b1;
            else if (wr_status && wdata[ST_FRAME_ERR]) frame_err_q <= 1'b0;
            if (tx_ovf_set)                         tx_ovf_q <= 1'b1;
            else if (wr_status && wdata[ST_TX_OVF]) tx_ovf_q <= 1'b0;
            irq_q <= (rx_irq_en_q && !rx_empty) || rx_ovf_q || frame_err_q;
        end
    end

    assign tx_valid = (state_q == TX_SEND);
    assign tx_data  = tx_valid ? tx_head : 8'h00;
    assign baud_div = baud_div_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: register access, TX/RX FIFO flow,
// overflow and frame-error stickies, IRQ latency and mid-send reset.
module tb_uart_mmio_ctrl;

    localparam logic [31:0] A_DATA   = 32'h0000_2000;
    localparam logic [31:0] A_STATUS = 32'h0000_2004;
    localparam logic [31:0] A_CTRL   = 32'h0000_2008;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we, re;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_frame_err;
    logic [15:0] baud_div;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [7:0]  sent[$];
    logic [31:0] rd;

    always #5 clk = ~clk;

    uart_mmio_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .we           (we),
        .re           (re),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .baud_div     (baud_div),
        .irq          (irq)
    );

    // Record every completed TX handshake
    always @(posedge clk) begin
        if (reset_n && tx_valid && tx_ready) sent.push_back(tx_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        re = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clk);
        re = 1'b0; addr = 32'h0;
    endtask

    task automatic rx_pulse(input logic [7:0] b, input logic ferr);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b; rx_frame_err = ferr;
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 8'h00; rx_frame_err = 1'b0;
    endtask

    task automatic wait_sent(input int n);
        for (int i = 0; i < 200 && sent.size() < n; i++) @(negedge clk);
        chk("tx_count", sent.size(), n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_frame_err = 1'b0;
        #22;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_baud", baud_div, 16'd521);
        chk("rst_irq", irq, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(A_STATUS, rd); chk("rst_status", rd, 32'h02);
        bus_read(A_CTRL, rd);   chk("rst_ctrl", rd, 32'h0001_0209);

        // Three bytes streamed with the serializer always ready
        tx_ready = 1'b1;
        bus_write(A_DATA, 32'h48);
        bus_write(A_DATA, 32'h65);
        bus_write(A_DATA, 32'h6C);
        wait_sent(3);
        chk("tx0", sent[0], 8'h48);
        chk("tx1", sent[1], 8'h65);
        chk("tx2", sent[2], 8'h6C);
        idle(3);
        bus_read(A_STATUS, rd); chk("tx_done_status", rd, 32'h02);

        // Overfill the TX FIFO while the serializer stalls
        sent.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'h11 + i);
        bus_read(A_STATUS, rd); chk("tx_full_status", rd, 32'hC1);
        chk("send_valid", tx_valid, 1);
        chk("send_data", tx_data, 8'h11);
        tx_ready = 1'b1;
        wait_sent(4);
        idle(10);
        chk("tx_no_fifth", sent.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("ovf_tx%0d", i), sent[i], 32'h11 + i);
        bus_read(A_STATUS, rd);   chk("tx_ovf_sticky", rd, 32'h82);
        bus_write(A_STATUS, 32'h80);
        bus_read(A_STATUS, rd);   chk("tx_ovf_clear", rd, 32'h02);

        // CTRL write of all zero: divisor kept, TX disabled
        sent.delete();
        bus_write(A_CTRL, 32'h0);
        chk("div0_baud", baud_div, 16'd521);
        bus_read(A_CTRL, rd); chk("div0_ctrl", rd, 32'h0000_0209);
        bus_write(A_DATA, 32'h77);
        idle(5);
        chk("txdis_valid", tx_valid, 0);
        bus_read(A_STATUS, rd); chk("txdis_status", rd, 32'h00);
        bus_write(A_CTRL, 32'h0001_1234);
        chk("new_baud", baud_div, 16'h1234);
        wait_sent(1);
        chk("txen_byte", sent[0], 8'h77);

        // RX with interrupt enabled; divisor field zero keeps 0x1234
        bus_write(A_CTRL, 32'h0003_0000);
        chk("keep_baud", baud_div, 16'h1234);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h48;
        @(negedge clk);
        rx_data = 8'h6F;
        chk("irq_latency", irq, 0);
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 8'h00;
        chk("irq_set", irq, 1);
        bus_read(A_DATA, rd); chk("rx0", rd, 32'h48);
        bus_read(A_DATA, rd); chk("rx1", rd, 32'h6F);
        bus_read(A_DATA, rd); chk("rx_empty_read", rd, 32'h0);
        idle(1);
        chk("irq_clear", irq, 0);

        // RX full: push with same-cycle pop succeeds, push alone overflows
        for (int i = 0; i < 4; i++) rx_pulse(8'hA0 + i, 1'b0);
        bus_read(A_STATUS, rd); chk("rx_full_status", rd, 32'h0E);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'hA4; re = 1'b1; addr = A_DATA;
        #1 chk("rx_pop_push", rdata, 32'hA0);
        @(negedge clk);
        rx_valid = 1'b0; re = 1'b0; addr = 32'h0;
        bus_read(A_STATUS, rd); chk("no_rx_ovf", rd, 32'h0E);
        rx_pulse(8'hA5, 1'b0);
        bus_read(A_STATUS, rd); chk("rx_ovf_set", rd, 32'h1E);
        bus_write(A_STATUS, 32'h10);
        bus_read(A_STATUS, rd); chk("rx_ovf_clear", rd, 32'h0E);
        for (int i = 1; i < 5; i++) begin
            bus_read(A_DATA, rd); chk($sformatf("rx_drain%0d", i), rd, 32'hA0 + i);
        end

        // Frame error: byte discarded, sticky set wins over same-cycle clear
        bus_write(A_CTRL, 32'h0001_0000);
        rx_pulse(8'h55, 1'b1);
        bus_read(A_STATUS, rd); chk("ferr_status", rd, 32'h22);
        chk("ferr_irq", irq, 1);
        @(negedge clk);
        rx_valid = 1'b1; rx_frame_err = 1'b1; we = 1'b1; addr = A_STATUS; wdata = 32'h20;
        @(negedge clk);
        rx_valid = 1'b0; rx_frame_err = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        bus_read(A_STATUS, rd); chk("ferr_set_wins", rd, 32'h22);
        bus_write(A_STATUS, 32'h20);
        bus_read(A_STATUS, rd); chk("ferr_clear", rd, 32'h02);
        idle(1);
        chk("ferr_irq_clear", irq, 0);

        // Unmapped addresses
        bus_write(32'h0000_200C, 32'hFFFF_FFFF);
        bus_read(32'h0000_200C, rd); chk("unmapped_rd", rd, 32'h0);
        bus_read(32'h0000_1000, rd); chk("far_rd", rd, 32'h0);
        bus_read(A_CTRL, rd);        chk("ctrl_untouched", rd, 32'h0001_1234);

        // Reset in the middle of SEND
        tx_ready = 1'b0;
        bus_write(A_DATA, 32'h99);
        idle(2);
        chk("pre_rst_valid", tx_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", tx_valid, 0);
        chk("async_data", tx_data, 0);
        chk("async_baud", baud_div, 16'd521);
        @(negedge clk);
        reset_n = 1'b1;
        tx_ready = 1'b1;
        bus_read(A_STATUS, rd); chk("post_rst_status", rd, 32'h02);
        bus_read(A_CTRL, rd);   chk("post_rst_ctrl", rd, 32'h0001_0209);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
